// File: rtl/inst_fetch_queue_pkg.sv
// Shared definitions for the IF->ID instruction fetch queue.
package inst_fetch_queue_pkg;

  localparam int IFQ_DEPTH    = 4;
  localparam int IFQ_PC_W     = 32;
  localparam int IFQ_INST_W   = 32;
  localparam int IFQ_ENTRY_WD = IFQ_PC_W + IFQ_INST_W;

  // Source of the instruction presented to ID.
  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_HEAD = 2'd1,
    SEL_RESP = 2'd2
  } ifq_sel_e;

  function automatic int ifq_entry_wd(input int pc_w, input int inst_w);
    return pc_w + inst_w;
  endfunction

endpackage

// File: rtl/inst_fetch_queue_ram.sv
// Entry storage for the fetch queue: one write port, asynchronous read port.
module ifq_ram #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/inst_fetch_queue.sv
// DEPTH-entry {pc, inst} buffer between IF and ID with fall-through and flush.
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int DEPTH  = IFQ_DEPTH,
  parameter int PC_W   = IFQ_PC_W,
  parameter int INST_W = IFQ_INST_W
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     flush,
  input  logic                     if_req,
  input  logic [PC_W-1:0]          if_pc,
  output logic                     fetch_ready,
  input  logic [INST_W-1:0]        inst_sram_rdata,
  output logic                     id_valid,
  output logic [PC_W-1:0]          id_pc,
  output logic [INST_W-1:0]        id_inst,
  input  logic                     id_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = ifq_entry_wd(PC_W, INST_W);
  localparam logic [CW-1:0] DEPTH_CNT  = CW'(DEPTH);
  localparam logic [CW:0]   DEPTH_WIDE = (CW + 1)'(DEPTH);

  logic            pend_v_reg, pend_v_next;
  logic [PC_W-1:0] pend_pc_reg, pend_pc_next;
  logic [AW-1:0]   head_reg, head_next;
  logic [AW-1:0]   tail_reg, tail_next;
  logic [CW-1:0]   count_reg, count_next;

  logic            resp_v;
  logic            queue_empty;
  logic            fall_through;
  logic            fetch_accept;
  logic            push;
  logic            pop;
  logic [CW:0]     committed;
  ifq_sel_e        sel;
  logic [EW-1:0]   head_entry;
  logic [EW-1:0]   resp_entry;

  assign resp_v      = pend_v_reg;
  assign queue_empty = (count_reg == '0);
  assign resp_entry  = {pend_pc_reg, inst_sram_rdata};

  // Credit counts the in-flight response so it always has a slot; a
  // same-cycle pop earns no credit.
  assign committed    = {1'b0, count_reg} + {{CW{1'b0}}, pend_v_reg};
  assign fetch_ready  = ~flush & (committed < DEPTH_WIDE);
  assign fetch_accept = if_req & fetch_ready;

  always_comb begin
    sel = SEL_NONE;
    if (!queue_empty) begin
      sel = SEL_HEAD;
    end else if (resp_v) begin
      sel = SEL_RESP;
    end
  end

  always_comb begin
    id_valid = 1'b0;
    id_pc    = '0;
    id_inst  = '0;
    case (sel)
      SEL_HEAD: begin
        id_valid          = 1'b1;
        {id_pc, id_inst}  = head_entry;
      end
      SEL_RESP: begin
        id_valid          = 1'b1;
        {id_pc, id_inst}  = resp_entry;
      end
      default: ;
    endcase
  end

  assign fall_through = (sel == SEL_RESP);
  // A fall-through response taken by ID this cycle never touches storage.
  assign push = resp_v & ~flush & ~(fall_through & id_ready);
  assign pop  = (sel == SEL_HEAD) & id_ready & ~flush;

  always_comb begin
    pend_v_next  = pend_v_reg;
    pend_pc_next = pend_pc_reg;
    head_next    = head_reg;
    tail_next    = tail_reg;
    count_next   = count_reg;
    if (flush) begin
      pend_v_next = 1'b0;
      head_next   = '0;
      tail_next   = '0;
      count_next  = '0;
    end else begin
      pend_v_next = fetch_accept;
      if (fetch_accept) begin
        pend_pc_next = if_pc;
      end
      if (push) begin
        tail_next = tail_reg + AW'(1);
      end
      if (pop) begin
        head_next = head_reg + AW'(1);
      end
      count_next = count_reg + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pend_v_reg  <= 1'b0;
      pend_pc_reg <= '0;
      head_reg    <= '0;
      tail_reg    <= '0;
      count_reg   <= '0;
    end else begin
      pend_v_reg  <= pend_v_next;
      pend_pc_reg <= pend_pc_next;
      head_reg    <= head_next;
      tail_reg    <= tail_next;
      count_reg   <= count_next;
    end
  end

  assign count = count_reg;

  ifq_ram #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (tail_reg),
    .wdata (resp_entry),
    .raddr (head_reg),
    .rdata (head_entry)
  );

  a_count_range: assert property (@(posedge clk) disable iff (!resetn)
    count_reg <= DEPTH_CNT);

  a_no_overflow: assert property (@(posedge clk) disable iff (!resetn)
    !(push && !pop && count_reg == DEPTH_CNT));

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Randomised and directed check of inst_fetch_queue against a queue-level model.
module tb_inst_fetch_queue;

  localparam int DEPTH  = 4;
  localparam int PC_W   = 32;
  localparam int INST_W = 32;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              flush = 1'b0;
  logic              if_req = 1'b0;
  logic [PC_W-1:0]   if_pc = '0;
  logic              fetch_ready;
  logic [INST_W-1:0] inst_sram_rdata = '0;
  logic              id_valid;
  logic [PC_W-1:0]   id_pc;
  logic [INST_W-1:0] id_inst;
  logic              id_ready = 1'b0;
  logic [2:0]        count;

  int n_checks = 0;
  int n_fail   = 0;

  inst_fetch_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .INST_W(INST_W)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .flush           (flush),
    .if_req          (if_req),
    .if_pc           (if_pc),
    .fetch_ready     (fetch_ready),
    .inst_sram_rdata (inst_sram_rdata),
    .id_valid        (id_valid),
    .id_pc           (id_pc),
    .id_inst         (id_inst),
    .id_ready        (id_ready),
    .count           (count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return (pc * 32'h9E3779B1) ^ 32'hA5A55A5A;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Synchronous SRAM: data for the address seen at an edge appears after it.
  always @(posedge clk) begin
    inst_sram_rdata <= if_req ? inst_of(if_pc) : $urandom;
  end

  // Model: ordered list of stored pcs plus the one fetch in flight.
  logic [31:0] mq[$];
  bit          m_pv = 1'b0;
  logic [31:0] m_ppc = '0;

  always @(negedge resetn) begin
    mq.delete();
    m_pv = 1'b0;
  end

  always @(negedge clk) begin
    bit          ev;
    bit          efr;
    bit          took_resp;
    logic [31:0] epc;
    if (!resetn) begin
      check("rst_id_valid", id_valid, 0);
      check("rst_count", count, 0);
      mq.delete();
      m_pv = 1'b0;
    end else begin
      efr = !flush && (mq.size() + int'(m_pv) < DEPTH);
      if (mq.size() > 0) begin
        ev = 1'b1; epc = mq[0];
      end else if (m_pv) begin
        ev = 1'b1; epc = m_ppc;
      end else begin
        ev = 1'b0; epc = '0;
      end
      check("m_id_valid", id_valid, ev);
      check("m_id_pc", id_pc, epc);
      check("m_id_inst", id_inst, ev ? inst_of(epc) : 32'h0);
      check("m_count", count, mq.size());
      check("m_fetch_ready", fetch_ready, efr);
      if (flush) begin
        mq.delete();
        m_pv = 1'b0;
      end else begin
        took_resp = 1'b0;
        if (ev && id_ready) begin
          if (mq.size() > 0) void'(mq.pop_front());
          else took_resp = 1'b1;
        end
        if (m_pv && !took_resp) mq.push_back(m_ppc);
        m_pv  = if_req && efr;
        m_ppc = if_pc;
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] pc;
    logic [31:0] exp_pc;
    int          accepted;
    int          pops;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_id_valid", id_valid, 0);
    check("reset_id_pc", id_pc, 0);
    check("reset_id_inst", id_inst, 0);
    check("reset_count", count, 0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    check("fetch_ready_after_reset", fetch_ready, 1);
    next_cycle();

    // Streaming through the fall-through path
    pc = 32'hBFC00000;
    for (int i = 0; i < 8; i++) begin
      if_req = 1'b1; if_pc = pc + 32'(4 * i); id_ready = 1'b1;
      @(negedge clk);
      if (i > 0) begin
        check("stream_valid", id_valid, 1);
        check("stream_pc", id_pc, 32'hBFC00000 + 32'(4 * (i - 1)));
        check("stream_count", count, 0);
      end
      next_cycle();
    end
    if_req = 1'b0;
    @(negedge clk);
    check("stream_last_pc", id_pc, 32'hBFC0001C);
    next_cycle();
    @(negedge clk);
    check("stream_idle", id_valid, 0);
    next_cycle();

    // Fill to full with ID stalled
    id_ready = 1'b0; pc = 32'h1000; accepted = 0;
    for (int i = 0; i < 8; i++) begin
      if_req = 1'b1; if_pc = pc;
      @(negedge clk);
      if (fetch_ready) begin accepted++; pc += 4; end
      next_cycle();
    end
    if_pc = pc;
    @(negedge clk);
    check("full_accepted", accepted, 4);
    check("full_count", count, 4);
    check("full_head_pc", id_pc, 32'h1000);
    check("full_fetch_ready", fetch_ready, 0);
    next_cycle();

    // Drain across pointer wrap while fetching
    exp_pc = 32'h1000; pops = 0;
    for (int i = 0; i < 6; i++) begin
      id_ready = 1'b1; if_req = 1'b1; if_pc = pc;
      @(negedge clk);
      if (fetch_ready) pc += 4;
      if (id_valid) begin
        check("drain_order", id_pc, exp_pc);
        exp_pc += 4; pops++;
      end
      next_cycle();
    end
    check("drain_pops", pops, 6);
    if_req = 1'b0;
    repeat (8) begin @(negedge clk); next_cycle(); end
    @(negedge clk);
    check("drained_count", count, 0);
    next_cycle();

    // Flush with three stored entries and one response in flight
    id_ready = 1'b0; pc = 32'h2000;
    for (int i = 0; i < 4; i++) begin
      if_req = 1'b1; if_pc = pc;
      @(negedge clk);
      check("flush_setup_accept", fetch_ready, 1);
      pc += 4;
      next_cycle();
    end
    flush = 1'b1; if_req = 1'b1; if_pc = 32'h3000;
    @(negedge clk);
    check("flush_cycle_count", count, 3);
    check("flush_cycle_fetch_ready", fetch_ready, 0);
    check("flush_cycle_head", id_pc, 32'h2000);
    next_cycle();
    flush = 1'b0; if_req = 1'b1; if_pc = 32'h80001000; id_ready = 1'b1;
    @(negedge clk);
    check("post_flush_count", count, 0);
    check("post_flush_valid", id_valid, 0);
    next_cycle();
    if_req = 1'b0;
    @(negedge clk);
    check("post_flush_first_valid", id_valid, 1);
    check("post_flush_first_pc", id_pc, 32'h80001000);
    check("post_flush_first_inst", id_inst, inst_of(32'h80001000));
    next_cycle();
    @(negedge clk);
    check("flushed_never_appear", id_valid, 0);
    next_cycle();

    // Asynchronous reset with two stored entries
    id_ready = 1'b0; pc = 32'h4000;
    for (int i = 0; i < 2; i++) begin
      if_req = 1'b1; if_pc = pc; pc += 4;
      @(negedge clk);
      next_cycle();
    end
    if_req = 1'b0;
    @(negedge clk);
    next_cycle();
    @(negedge clk);
    check("pre_reset_count", count, 2);
    check("pre_reset_valid", id_valid, 1);
    #2 resetn = 1'b0;
    #1;
    check("async_reset_valid", id_valid, 0);
    check("async_reset_count", count, 0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    check("post_reset_fetch_ready", fetch_ready, 1);
    next_cycle();

    // Randomised traffic
    pc = 32'h00400000;
    for (int i = 0; i < 3000; i++) begin
      if_req   = ($urandom_range(0, 3) != 0);
      id_ready = ($urandom_range(0, 2) != 0);
      flush    = ($urandom_range(0, 19) == 0);
      if_pc    = pc;
      @(negedge clk);
      if (flush) pc = $urandom & 32'hFFFFFFFC;
      else if (if_req && fetch_ready) pc += 4;
      next_cycle();
    end
    if_req = 1'b0; flush = 1'b0; id_ready = 1'b1;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
